// File: rtl/ascii_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ascii_to_7seg
// Description : Combinational ASCII to seven-segment decoder for a
//               common-anode display. Letters are case-insensitive. Any
//               character without a glyph decodes to blank.
// Ports       : char_in [7:0] ASCII code in
//               seg     [6:0] active-low segments {a,b,c,d,e,f,g}
//               an      [7:0] active-low anode select (single-digit use)
// Revision    : 1.0  initial release
// ============================================================================
module ascii_to_7seg (
    input  logic [7:0] char_in,
    output logic [6:0] seg,
    output logic [7:0] an
);

    logic [7:0] w_upper;

    always_comb begin
        w_upper = char_in;
        if ((char_in >= 8'h61) && (char_in <= 8'h7A)) begin
            w_upper = char_in - 8'h20;
        end

        case (w_upper)
            8'h30: seg = 7'b0000001; // 0
            8'h31: seg = 7'b1001111; // 1
            8'h32: seg = 7'b0010010; // 2
            8'h33: seg = 7'b0000110; // 3
            8'h34: seg = 7'b1001100; // 4
            8'h35: seg = 7'b0100100; // 5
            8'h36: seg = 7'b0100000; // 6
            8'h37: seg = 7'b0001111; // 7
            8'h38: seg = 7'b0000000; // 8
            8'h39: seg = 7'b0000100; // 9
            8'h41: seg = 7'b0001000; // A
            8'h42: seg = 7'b1100000; // b
            8'h43: seg = 7'b0110001; // C
            8'h44: seg = 7'b1000010; // d
            8'h45: seg = 7'b0110000; // E
            8'h46: seg = 7'b0111000; // F
            8'h47: seg = 7'b0100001; // G
            8'h48: seg = 7'b1001000; // H
            8'h49: seg = 7'b1111001; // I
            8'h4A: seg = 7'b1000011; // J
            8'h4B: seg = 7'b0101000; // K
            8'h4C: seg = 7'b1110001; // L
            8'h4D: seg = 7'b0101011; // M
            8'h4E: seg = 7'b1101010; // n
            8'h4F: seg = 7'b0000001; // O
            8'h50: seg = 7'b0011000; // P
            8'h51: seg = 7'b0001100; // q
            8'h52: seg = 7'b1111010; // r
            8'h53: seg = 7'b0100100; // S
            8'h54: seg = 7'b1110000; // t
            8'h55: seg = 7'b1000001; // U
            8'h56: seg = 7'b1100011; // v
            8'h57: seg = 7'b1010101; // W
            8'h58: seg = 7'b1001000; // X
            8'h59: seg = 7'b1000100; // y
            8'h5A: seg = 7'b0010010; // Z
            8'h2D: seg = 7'b1111110; // -
            8'h5F: seg = 7'b1110111; // _
            default: seg = 7'h7F;    // blank
        endcase

        an = 8'hFE;
    end

endmodule

// ============================================================================
// Module      : ascii_display_scanner
// Description : Eight-character right-entry scrolling text buffer fed by a
//               UART receive strobe, time-multiplexed onto an 8-digit
//               common-anode seven-segment display.
// Ports       : clk, rst              clock, synchronous active-high reset
//               char_in [7:0]         received ASCII byte
//               char_valid            one-cycle strobe qualifying char_in
//               clear                 synchronous buffer clear
//               seg [6:0], dp         active-low segments / decimal point
//               an [7:0]              active-low anodes, one low at a time
//               char_count [3:0]      characters held (0..8)
// Revision    : 1.0  initial release
// ============================================================================
module ascii_display_scanner #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    input  logic       clear,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic [3:0] char_count
);

    localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Buffer state: index 0 is the rightmost digit.
    logic [7:0]         char_buf_q [8];
    logic [7:0]         char_buf_d [8];
    logic [7:0]         dpb_q, dpb_d;
    logic [3:0]         count_q, count_d;

    // Scan state
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]         idx_q, idx_d;

    // Registered display outputs
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [7:0]         an_q, an_d;

    logic [6:0]         w_dec_seg;
    logic [7:0]         w_cur_char;
    logic               w_clear_req;
    logic               w_shift_in;
    logic [7:0]         w_ins_char;
    logic               w_ins_dp;

    // ------------------------------------------------------------------
    // Buffer update
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            char_buf_d[i] = char_buf_q[i];
        end
        dpb_d      = dpb_q;
        count_d    = count_q;
        w_shift_in = 1'b0;
        w_ins_char = CH_SPACE;
        w_ins_dp   = 1'b0;

        // CR and LF behave exactly like the clear input.
        w_clear_req = clear |
                      (char_valid & ((char_in == 8'h0D) || (char_in == 8'h0A)));

        if (w_clear_req) begin
            for (int i = 0; i < 8; i++) begin
                char_buf_d[i] = CH_SPACE;
            end
            dpb_d   = 8'h00;
            count_d = 4'd0;
        end else if (char_valid) begin
            if (char_in == 8'h08) begin
                if (count_q != 4'd0) begin
                    for (int i = 0; i < 7; i++) begin
                        char_buf_d[i] = char_buf_q[i+1];
                    end
                    char_buf_d[7] = CH_SPACE;
                    dpb_d         = {1'b0, dpb_q[7:1]};
                    count_d       = count_q - 4'd1;
                end
            end else if (char_in == 8'h2E) begin
                // A dot attaches to the newest character if it has none yet,
                // otherwise it occupies a digit of its own on a blank.
                if ((count_q != 4'd0) && !dpb_q[0]) begin
                    dpb_d[0] = 1'b1;
                end else begin
                    w_shift_in = 1'b1;
                    w_ins_char = CH_SPACE;
                    w_ins_dp   = 1'b1;
                end
            end else if ((char_in >= 8'h20) && (char_in <= 8'h7E)) begin
                w_shift_in = 1'b1;
                w_ins_char = char_in;
                w_ins_dp   = 1'b0;
            end
        end

        if (w_shift_in) begin
            for (int i = 7; i > 0; i--) begin
                char_buf_d[i] = char_buf_q[i-1];
            end
            char_buf_d[0] = w_ins_char;
            dpb_d         = {dpb_q[6:0], w_ins_dp};
            count_d       = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Scan timing and output registration
    // ------------------------------------------------------------------
    assign w_cur_char = char_buf_q[idx_q];

    ascii_to_7seg u_dec (
        .char_in (w_cur_char),
        .seg     (w_dec_seg),
        .an      ()
    );

    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end

        // All three outputs come from the same idx_q so anode and segment
        // data always switch on the same edge.
        an_d  = ~(8'b1 << idx_q);
        seg_d = w_dec_seg;
        dp_d  = ~dpb_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                char_buf_q[i] <= CH_SPACE;
            end
            dpb_q   <= 8'h00;
            count_q <= 4'd0;
            presc_q <= '0;
            idx_q   <= 3'd0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 8'hFE;
        end else begin
            for (int i = 0; i < 8; i++) begin
                char_buf_q[i] <= char_buf_d[i];
            end
            dpb_q   <= dpb_d;
            count_q <= count_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign char_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ascii_display_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ascii_display_scanner
// Description : Randomized and directed self-checking bench for
//               ascii_display_scanner with SCAN_DIV = 4. A queue-based text
//               model supplies expected outputs every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ascii_display_scanner;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] char_in = 8'h00;
    logic       char_valid = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [3:0] char_count;

    ascii_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .clear      (clear),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the text is a queue, newest character at the front.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] ch;
        logic       dp;
    } ent_t;

    ent_t       mq[$];
    int         m_cyc = 0;   // clk edges since the last reset edge
    logic [7:0] exp_an  = 8'hFE;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= "a" && c <= "z") u = c - 8'd32;
        case (u)
            "0": return 7'b0000001; "1": return 7'b1001111;
            "2": return 7'b0010010; "3": return 7'b0000110;
            "4": return 7'b1001100; "5": return 7'b0100100;
            "6": return 7'b0100000; "7": return 7'b0001111;
            "8": return 7'b0000000; "9": return 7'b0000100;
            "A": return 7'b0001000; "B": return 7'b1100000;
            "C": return 7'b0110001; "D": return 7'b1000010;
            "E": return 7'b0110000; "F": return 7'b0111000;
            "G": return 7'b0100001; "H": return 7'b1001000;
            "I": return 7'b1111001; "J": return 7'b1000011;
            "K": return 7'b0101000; "L": return 7'b1110001;
            "M": return 7'b0101011; "N": return 7'b1101010;
            "O": return 7'b0000001; "P": return 7'b0011000;
            "Q": return 7'b0001100; "R": return 7'b1111010;
            "S": return 7'b0100100; "T": return 7'b1110000;
            "U": return 7'b1000001; "V": return 7'b1100011;
            "W": return 7'b1010101; "X": return 7'b1001000;
            "Y": return 7'b1000100; "Z": return 7'b0010010;
            "-": return 7'b1111110; "_": return 7'b1110111;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic ent_t pos(input int p);
        ent_t e;
        e.ch = 8'h20;
        e.dp = 1'b0;
        if (p < mq.size()) e = mq[p];
        return e;
    endfunction

    task automatic push_new(input logic [7:0] c, input logic d);
        ent_t e;
        e.ch = c;
        e.dp = d;
        mq.push_front(e);
        if (mq.size() > 8) mq.delete(8);
    endtask

    task automatic model_edge(input logic r, input logic c, input logic v, input logic [7:0] ch);
        int   idx;
        ent_t e;
        if (r) begin
            mq.delete();
            m_cyc   = 0;
            exp_an  = 8'hFE;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            // Display shows the digit selected before this edge.
            idx     = (m_cyc / SCAN_DIV) % 8;
            e       = pos(idx);
            exp_an  = ~(8'b1 << idx);
            exp_seg = glyph(e.ch);
            exp_dp  = ~e.dp;
            m_cyc++;
            if (c || (v && (ch == 8'h0D || ch == 8'h0A))) begin
                mq.delete();
            end else if (v) begin
                if (ch == 8'h08) begin
                    if (mq.size() > 0) mq.delete(0);
                end else if (ch == ".") begin
                    if (mq.size() > 0 && !mq[0].dp) mq[0].dp = 1'b1;
                    else push_new(8'h20, 1'b1);
                end else if (ch >= 8'h20 && ch <= 8'h7E) begin
                    push_new(ch, 1'b0);
                end
            end
        end
    endtask

    // One clock: apply inputs, advance model on the edge, check at negedge.
    task automatic tick(input logic r, input logic c, input logic v, input logic [7:0] ch);
        rst = r; clear = c; char_valid = v; char_in = ch;
        @(posedge clk);
        model_edge(r, c, v, ch);
        @(negedge clk);
        rst = 1'b0; clear = 1'b0; char_valid = 1'b0; char_in = 8'h00;
        chk("an",    {24'd0, an},         {24'd0, exp_an});
        chk("seg",   {25'd0, seg},        {25'd0, exp_seg});
        chk("dp",    {31'd0, dp},         {31'd0, exp_dp});
        chk("count", {28'd0, char_count}, mq.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] ch);
        tick(1'b0, 1'b0, 1'b1, ch);
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n;
        n = 0;
        while (an !== target && n < 40) begin
            idle(1);
            n++;
        end
        if (n >= 40) chk("wait_an", {24'd0, an}, {24'd0, target});
    endtask

    string s;

    initial begin
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_an",  {24'd0, an},  32'hFE);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp",  {31'd0, dp},  32'h1);
        idle(40);

        // "12.3"
        send("1"); send("2"); send("."); send("3");
        idle(2);
        chk("p2_count", {28'd0, char_count}, 32'd3);
        wait_an(8'hFE);
        chk("p2_seg0", {25'd0, seg}, {25'd0, 7'b0000110});
        chk("p2_dp0",  {31'd0, dp},  32'd1);
        wait_an(8'hFD);
        chk("p2_seg1", {25'd0, seg}, {25'd0, 7'b0010010});
        chk("p2_dp1",  {31'd0, dp},  32'd0);
        wait_an(8'hFB);
        chk("p2_seg2", {25'd0, seg}, {25'd0, 7'b1001111});

        // Overflow: 9 characters into 8 digits
        s = "ABCDEFGHJ";
        for (int i = 0; i < s.len(); i++) send(s[i]);
        idle(1);
        chk("p3_count", {28'd0, char_count}, 32'd8);
        wait_an(8'h7F);
        chk("p3_seg7", {25'd0, seg}, {25'd0, 7'b1100000});
        wait_an(8'hFE);
        chk("p3_seg0", {25'd0, seg}, {25'd0, 7'b1000011});

        // Backspace
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        send("1"); idle(1); send("2"); idle(1);
        send(8'h08); idle(1);
        chk("bs1_count", {28'd0, char_count}, 32'd1);
        wait_an(8'hFE);
        chk("bs1_seg0", {25'd0, seg}, {25'd0, 7'b1001111});
        send(8'h08); idle(1);
        chk("bs2_count", {28'd0, char_count}, 32'd0);
        wait_an(8'hFE);
        chk("bs2_seg0", {25'd0, seg}, 32'h7F);
        send(8'h08); idle(1);
        chk("bs3_count", {28'd0, char_count}, 32'd0);

        // Clear beats a simultaneous character; control byte ignored
        send("Q");
        tick(1'b0, 1'b1, 1'b1, "A");
        chk("clr_count", {28'd0, char_count}, 32'd0);
        send(8'h05); idle(2);
        chk("ign_count", {28'd0, char_count}, 32'd0);
        wait_an(8'hFE);
        chk("ign_seg0", {25'd0, seg}, 32'h7F);

        // Reset mid-scan with a full buffer
        s = "87654321";
        for (int i = 0; i < s.len(); i++) send(s[i]);
        wait_an(8'hF7);
        tick(1'b1, 1'b0, 1'b1, "Z");
        chk("mrst_an",    {24'd0, an},         32'hFE);
        chk("mrst_seg",   {25'd0, seg},        32'h7F);
        chk("mrst_dp",    {31'd0, dp},         32'h1);
        chk("mrst_count", {28'd0, char_count}, 32'd0);
        idle(10);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic       r, c, v;
            logic [7:0] ch;
            int         sel;
            r   = ($urandom_range(0, 499) == 0);
            c   = ($urandom_range(0, 99) == 0);
            v   = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4: ch = 8'($urandom_range(8'h20, 8'h7E));
                5:             ch = ".";
                6:             ch = 8'h08;
                7:             ch = ($urandom_range(0, 3) == 0) ?
                                    (($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A) : ".";
                8:             ch = 8'($urandom_range(0, 255));
                default:       ch = 8'("0" + $urandom_range(0, 9));
            endcase
            tick(r, c, v, ch);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
